// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port cache/memory arbiter.
// Optional macro MEM_ARB_RR_EN selects round-robin arbitration in mem_arb_pick.
package mem_arb_pkg;

  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned DATA_W_DEF = 256;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = 3'h0,
    GRANT0 = 3'h1,
    GRANT1 = 3'h2,
    RESP0  = 3'h3,
    RESP1  = 3'h4
  } arb_state_e;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select between the two requesters.
// MEM_ARB_RR_EN defined: round-robin on contention; undefined: port 1 always first.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  output logic       winner_o
);

`ifdef MEM_ARB_RR_EN
  always_comb begin
    if (req_i == 2'b11) winner_o = ~last_grant_i;
    else                winner_o = req_i[1] ? PORT1 : PORT0;
  end
`else
  logic unused_last_grant;
  assign unused_last_grant = last_grant_i;

  always_comb begin
    winner_o = req_i[1] ? PORT1 : PORT0;
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Shares one cache-line memory port between I-cache (port 0) and D-cache (port 1).
// Grant held until mem_ack_i; arbitration mode chosen by MEM_ARB_RR_EN (see mem_arb_pick).
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              m0_enable_i,
  input  logic              m0_write_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [DATA_W-1:0] m0_data_i,
  output logic [DATA_W-1:0] m0_data_o,
  output logic              m0_ack_o,
  input  logic              m1_enable_i,
  input  logic              m1_write_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [DATA_W-1:0] m1_data_i,
  output logic [DATA_W-1:0] m1_data_o,
  output logic              m1_ack_o,
  input  logic [DATA_W-1:0] mem_data_i,
  input  logic              mem_ack_i,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_data_o,
  output logic [1:0]        grant_o
);

  arb_state_e        state_q, state_d;
  logic              mem_enable_q, mem_enable_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_data_q, mem_data_d;
  logic [DATA_W-1:0] m0_data_q, m0_data_d;
  logic [DATA_W-1:0] m1_data_q, m1_data_d;
  logic              m0_ack_q, m0_ack_d;
  logic              m1_ack_q, m1_ack_d;
  logic              last_grant_q, last_grant_d;
  logic              winner;

  mem_arb_pick u_pick (
    .req_i        ({m1_enable_i, m0_enable_i}),
    .last_grant_i (last_grant_q),
    .winner_o     (winner)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      mem_enable_q <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
      m0_data_q    <= '0;
      m1_data_q    <= '0;
      m0_ack_q     <= 1'b0;
      m1_ack_q     <= 1'b0;
      last_grant_q <= PORT0;
    end else begin
      state_q      <= state_d;
      mem_enable_q <= mem_enable_d;
      mem_write_q  <= mem_write_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_q   <= mem_data_d;
      m0_data_q    <= m0_data_d;
      m1_data_q    <= m1_data_d;
      m0_ack_q     <= m0_ack_d;
      m1_ack_q     <= m1_ack_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Acks default low so they can only be high for the single RESPx cycle.
  always_comb begin
    state_d      = state_q;
    mem_enable_d = mem_enable_q;
    mem_write_d  = mem_write_q;
    mem_addr_d   = mem_addr_q;
    mem_data_d   = mem_data_q;
    m0_data_d    = m0_data_q;
    m1_data_d    = m1_data_q;
    m0_ack_d     = 1'b0;
    m1_ack_d     = 1'b0;
    last_grant_d = last_grant_q;
    case (state_q)
      IDLE: begin
        if (m0_enable_i || m1_enable_i) begin
          mem_enable_d = 1'b1;
          if (winner == PORT1) begin
            mem_write_d = m1_write_i;
            mem_addr_d  = m1_addr_i;
            mem_data_d  = m1_data_i;
            state_d     = GRANT1;
          end else begin
            mem_write_d = m0_write_i;
            mem_addr_d  = m0_addr_i;
            mem_data_d  = m0_data_i;
            state_d     = GRANT0;
          end
        end
      end
      GRANT0: begin
        if (mem_ack_i) begin
          mem_enable_d = 1'b0;
          if (!mem_write_q) m0_data_d = mem_data_i;
          m0_ack_d = 1'b1;
          state_d  = RESP0;
        end
      end
      GRANT1: begin
        if (mem_ack_i) begin
          mem_enable_d = 1'b0;
          if (!mem_write_q) m1_data_d = mem_data_i;
          m1_ack_d = 1'b1;
          state_d  = RESP1;
        end
      end
      RESP0: begin
        last_grant_d = PORT0;
        state_d      = IDLE;
      end
      RESP1: begin
        last_grant_d = PORT1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    case (state_q)
      GRANT0, RESP0: grant_o = 2'b01;
      GRANT1, RESP1: grant_o = 2'b10;
      default:       grant_o = 2'b00;
    endcase
  end

  assign mem_enable_o = mem_enable_q;
  assign mem_write_o  = mem_write_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_data_o   = mem_data_q;
  assign m0_data_o    = m0_data_q;
  assign m1_data_o    = m1_data_q;
  assign m0_ack_o     = m0_ack_q;
  assign m1_ack_o     = m1_ack_q;

endmodule
